// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default widths, instruction field positions
// and the ALU operation encodings that the EX stage decodes.
package pipeline_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int INSTR_W    = 32;
  localparam int ALU_OP_W   = 3;

  // Instruction field bit positions (R/I-type layout)
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_NOR = 3'd5,
    ALU_XOR = 3'd6,
    ALU_SLL = 3'd7
  } alu_op_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: requests a one-cycle stall when the load in EX
// writes a register the ID instruction reads. Register 0 never hazards.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  output logic              stall
);

  // Pure compare; stall must be visible in the same cycle to hold PC and IF/ID
  assign stall = ex_mem_read && (ex_rt != '0) && ((ex_rt == rs) || (ex_rt == rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and branch flush.
// Optional macro ID_EX_BYPASS_EN: forward the write-back bus into the
// captured operands when it targets rs/rt in the same cycle.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [INSTR_W-1:0]  instr,
  input  logic [DATA_W-1:0]   pc_plus4,
  input  logic [DATA_W-1:0]   data1,
  input  logic [DATA_W-1:0]   data2,
  input  logic                reg_write,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                mem_to_reg,
  input  logic                alu_src,
  input  logic                reg_dst,
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic                wb_reg_write,
  input  logic [REG_AW-1:0]   wb_write_reg,
  input  logic [DATA_W-1:0]   wb_write_data,
  output logic                stall,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_mem_to_reg,
  output logic                ex_alu_src,
  output logic                ex_reg_dst,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [DATA_W-1:0]   ex_pc_plus4,
  output logic [DATA_W-1:0]   ex_data1,
  output logic [DATA_W-1:0]   ex_data2,
  output logic [DATA_W-1:0]   ex_imm,
  output logic [REG_AW-1:0]   ex_rs,
  output logic [REG_AW-1:0]   ex_rt,
  output logic [REG_AW-1:0]   ex_rd
);

  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              bubble;
  logic              unused_opcode;

  // Field decode; opcode/funct are consumed by the control decoder upstream
  assign rs  = REG_AW'(instr[RS_MSB:RS_LSB]);
  assign rt  = REG_AW'(instr[RT_MSB:RT_LSB]);
  assign rd  = REG_AW'(instr[RD_MSB:RD_LSB]);
  assign imm = {{(DATA_W-IMM_W){instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};
  assign unused_opcode = ^instr[INSTR_W-1:RS_MSB+1];

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .rs          (rs),
    .rt          (rt),
    .stall       (stall)
  );

  // Operand selection for capture: optional write-back bypass onto rs/rt data
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    op1 = data1;
    op2 = data2;
`ifdef ID_EX_BYPASS_EN
    if (wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == rs)) op1 = wb_write_data;
    if (wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == rt)) op2 = wb_write_data;
`else
    // Register file writes on the falling edge, so data1/data2 already see WB
`endif
  end

  // flush and stall both insert a bubble; a simultaneous pair is still one bubble
  assign bubble = flush || stall;

  // Pipeline register: rst > bubble > capture, all synchronous
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_alu_op     <= '0;
      ex_pc_plus4   <= '0;
      ex_data1      <= '0;
      ex_data2      <= '0;
      ex_imm        <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
    end else begin
      ex_reg_write  <= reg_write;
      ex_mem_read   <= mem_read;
      ex_mem_write  <= mem_write;
      ex_mem_to_reg <= mem_to_reg;
      ex_alu_src    <= alu_src;
      ex_reg_dst    <= reg_dst;
      ex_alu_op     <= alu_op;
      ex_pc_plus4   <= pc_plus4;
      ex_data1      <= op1;
      ex_data2      <= op2;
      ex_imm        <= imm;
      ex_rs         <= rs;
      ex_rt         <= rt;
      ex_rd         <= rd;
    end
  end

endmodule
